control_cmd_fillarea: RTL and testbench

CONTROL_CMD_FILLAREA -- requirements
Module: control_cmd_fillarea

---
 rtl/control_cmd_fillarea.sv | 139 +++++++++++++
 tb/tb_control_cmd_fillarea.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_fillarea.sv
// Fill-area command decoder: collects rectangle/color payload bytes, bounds-checks the
// rectangle, launches the downstream fill subcommand and reports completion.
package params;
  localparam int unsigned BYTES_PER_PIXEL = 2;
  localparam int unsigned PIXEL_WIDTH     = 64;
  localparam int unsigned PIXEL_HEIGHT    = 32;
endpackage

package calc_pkg;
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

module control_cmd_fillarea #(
  parameter int unsigned BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
  parameter int unsigned PIXEL_WIDTH     = params::PIXEL_WIDTH,
  parameter int unsigned PIXEL_HEIGHT    = params::PIXEL_HEIGHT
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [7:0]                                    data_in,
  input  logic                                          data_valid,
  input  logic                                          subcmd_done,
  output logic                                          subcmd_enable,
  output logic                                          subcmd_ack,
  output logic [calc_pkg::addr_w(PIXEL_WIDTH)-1:0]      x1,
  output logic [calc_pkg::addr_w(PIXEL_HEIGHT)-1:0]     y1,
  output logic [calc_pkg::addr_w(PIXEL_WIDTH)-1:0]      width,
  output logic [calc_pkg::addr_w(PIXEL_HEIGHT)-1:0]     height,
  output logic [BYTES_PER_PIXEL*8-1:0]                  color,
  output logic                                          done,
  output logic                                          error
);

  localparam int unsigned CW = calc_pkg::addr_w(PIXEL_WIDTH);
  localparam int unsigned RW = calc_pkg::addr_w(PIXEL_HEIGHT);
  localparam logic [1:0]  CNT_LAST = 2'(BYTES_PER_PIXEL - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] GET_X1    = 4'd1;
  localparam logic [3:0] GET_Y1    = 4'd2;
  localparam logic [3:0] GET_W     = 4'd3;
  localparam logic [3:0] GET_H     = 4'd4;
  localparam logic [3:0] GET_COLOR = 4'd5;
  localparam logic [3:0] CHECK     = 4'd6;
  localparam logic [3:0] RUN       = 4'd7;
  localparam logic [3:0] ACK       = 4'd8;
  localparam logic [3:0] FINISH    = 4'd9;

  logic [3:0]                   state;
  logic                         enable_q;
  logic [7:0]                   x1_q, y1_q, w_q, h_q;
  logic [BYTES_PER_PIXEL*8-1:0] color_q;
  logic [1:0]                   cnt;
  logic                         err_q;
  logic [8:0]                   x_end, y_end;
  logic                         reject;

  // Rectangle end coordinates kept at 9 bits so 255+255 cannot wrap into range
  always_comb begin
    x_end  = {1'b0, x1_q} + {1'b0, w_q};
    y_end  = {1'b0, y1_q} + {1'b0, h_q};
    reject = (w_q == '0) || (h_q == '0) ||
             (x_end > 9'(PIXEL_WIDTH)) || (y_end > 9'(PIXEL_HEIGHT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      x1_q     <= '0;
      y1_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      enable_q <= enable;
      case (state)
        IDLE: if (enable && !enable_q) begin
          state <= GET_X1;
          cnt   <= '0;
        end
        GET_X1: if (!enable) state <= IDLE;
                else if (data_valid) begin x1_q <= data_in; state <= GET_Y1; end
        GET_Y1: if (!enable) state <= IDLE;
                else if (data_valid) begin y1_q <= data_in; state <= GET_W; end
        GET_W:  if (!enable) state <= IDLE;
                else if (data_valid) begin w_q <= data_in; state <= GET_H; end
        GET_H:  if (!enable) state <= IDLE;
                else if (data_valid) begin h_q <= data_in; state <= GET_COLOR; end
        GET_COLOR: begin
          if (!enable) begin
            state <= IDLE;
          end else if (data_valid) begin
            // Byte k of the payload lands in lane BPP-1-k (first byte is most significant)
            for (int unsigned i = 0; i < BYTES_PER_PIXEL; i++)
              if (cnt == 2'(BYTES_PER_PIXEL - 1 - i)) color_q[i*8 +: 8] <= data_in;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= CHECK;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        CHECK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (reject) begin
            err_q <= 1'b1;
            state <= FINISH;
          end else begin
            err_q <= 1'b0;
            state <= RUN;
          end
        end
        RUN:     if (subcmd_done) state <= ACK;
        ACK:     state <= FINISH;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign subcmd_enable = (state == RUN);
  assign subcmd_ack    = (state == ACK);
  assign done          = (state == FINISH);
  assign error         = (state == FINISH) && err_q;
  assign x1            = x1_q[CW-1:0];
  assign y1            = y1_q[RW-1:0];
  assign width         = w_q[CW-1:0];
  assign height        = h_q[RW-1:0];
  assign color         = color_q;

endmodule

// File: tb/tb_control_cmd_fillarea.sv
// Directed bench for control_cmd_fillarea at BPP=2, 64x32.
module tb_control_cmd_fillarea;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        subcmd_done = 1'b0;
  logic        subcmd_enable, subcmd_ack, done, error;
  logic [5:0]  x1, width;
  logic [4:0]  y1, height;
  logic [15:0] color;

  int unsigned errors = 0;
  int unsigned checks = 0;

  control_cmd_fillarea #(
    .BYTES_PER_PIXEL(2),
    .PIXEL_WIDTH(64),
    .PIXEL_HEIGHT(32)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .subcmd_done(subcmd_done),
    .subcmd_enable(subcmd_enable), .subcmd_ack(subcmd_ack),
    .x1(x1), .y1(y1), .width(width), .height(height), .color(color),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the DUT in CHECK at the returning negedge.
  task automatic send_cmd(input logic [7:0] b0, b1, b2, b3, b4, b5);
    logic [7:0] b [6];
    b = '{b0, b1, b2, b3, b4, b5};
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      data_in    = b[i];
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_en", subcmd_enable, 0);
    chk("rst_ack", subcmd_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_color", color, 0);
    chk("rst_x1", x1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Nominal command with a 20-cycle fill
    send_cmd(8'h04, 8'h02, 8'h08, 8'h03, 8'hA5, 8'h5A);
    chk("t1_x1", x1, 4);
    chk("t1_y1", y1, 2);
    chk("t1_w", width, 8);
    chk("t1_h", height, 3);
    chk("t1_color", color, 16'hA55A);
    chk("t1_en_check", subcmd_enable, 0);
    @(negedge clk);
    chk("t1_en_run", subcmd_enable, 1);
    for (int i = 0; i < 19; i++) @(negedge clk);
    chk("t1_en_hold", subcmd_enable, 1);
    chk("t1_nodone", done, 0);
    subcmd_done = 1'b1;
    @(negedge clk);
    subcmd_done = 1'b0;
    chk("t1_ack", subcmd_ack, 1);
    chk("t1_en_ack", subcmd_enable, 0);
    @(negedge clk);
    chk("t1_ack_off", subcmd_ack, 0);
    chk("t1_done", done, 1);
    chk("t1_err", error, 0);
    @(negedge clk);
    chk("t1_done_off", done, 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("t1_no_relaunch", subcmd_enable, 0);

    // Full-frame rectangle, exact right/bottom edge
    send_cmd(8'h00, 8'h00, 8'h40, 8'h20, 8'hFF, 8'hFF);
    chk("t2_w_trunc", width, 0);
    chk("t2_h_trunc", height, 0);
    chk("t2_color", color, 16'hFFFF);
    @(negedge clk);
    chk("t2_en_run", subcmd_enable, 1);
    subcmd_done = 1'b1;
    @(negedge clk);
    subcmd_done = 1'b0;
    chk("t2_ack", subcmd_ack, 1);
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_err", error, 0);

    // Overruns right edge by one
    send_cmd(8'h3C, 8'h00, 8'h05, 8'h01, 8'h11, 8'h22);
    chk("t3_en_check", subcmd_enable, 0);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_err", error, 1);
    chk("t3_en", subcmd_enable, 0);
    @(negedge clk);
    chk("t3_done_off", done, 0);

    // Zero width, then zero height
    send_cmd(8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_err", error, 1);
    send_cmd(8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_err", error, 1);
    chk("t5_en", subcmd_enable, 0);

    // Abort after three bytes, then restart from x1
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(i + 9);
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_abort_nodone", done, 0);
    end
    send_cmd(8'h05, 8'h06, 8'h07, 8'h08, 8'h12, 8'h34);
    chk("t6_x1", x1, 5);
    chk("t6_h", height, 8);
    chk("t6_color", color, 16'h1234);
    @(negedge clk);
    enable = 1'b0;                         // ignored during RUN
    @(negedge clk);
    chk("t6_en_run", subcmd_enable, 1);
    subcmd_done = 1'b1;
    @(negedge clk);
    subcmd_done = 1'b0;
    chk("t6_ack", subcmd_ack, 1);
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_err", error, 0);

    // Asynchronous reset mid-RUN
    send_cmd(8'h02, 8'h02, 8'h02, 8'h02, 8'hBE, 8'hEF);
    @(negedge clk);
    chk("t7_en_run", subcmd_enable, 1);
    #2;
    reset = 1'b0;
    enable = 1'b0;
    #1;
    chk("t7_rst_en", subcmd_enable, 0);
    chk("t7_rst_color", color, 0);
    chk("t7_rst_x1", x1, 0);
    chk("t7_rst_w", width, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t7_post_done", done, 0);
    end
    chk("t7_post_en", subcmd_enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
